// File: rtl/mc_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath:
// instruction fields and the zero flag in, datapath selects and enables out.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM, ALU decoder and branch-aware
// PC enable. The 4-bit state register is the only storage.
module mc_controller (
    input  logic               clk,
    input  logic               reset,
    mc_controller_if.master    bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t      state_r;
    state_t      next_state_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic        branchne_s;
    logic        iord_s;
    logic        irwrite_s;
    logic        memwrite_s;
    logic        regwrite_s;
    logic        regdst_s;
    logic        memtoreg_s;
    logic        alusrca_s;
    logic [1:0]  alusrcb_s;
    logic [1:0]  pcsrc_s;
    logic [1:0]  aluop_s;
    logic [2:0]  alucontrol_s;

    // State register; reset forces FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH:   next_state_s = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYP:      next_state_s = RTYPEEX;
                    OP_BEQ:       next_state_s = BEQEX;
                    OP_BNE:       next_state_s = BNEEX;
                    OP_ADDI:      next_state_s = ADDIEX;
                    OP_J:         next_state_s = JEX;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW) begin
                    next_state_s = MEMRD;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            MEMRD:   next_state_s = MEMWB;
            RTYPEEX: next_state_s = RTYPEWB;
            ADDIEX:  next_state_s = ADDIWB;
            default: next_state_s = FETCH;
        endcase
    end

    // Moore control word per state; anything not set stays 0.
    always_comb begin
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        branchne_s = 1'b0;
        iord_s     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop_s    = 2'b00;
        case (state_r)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
                alusrcb_s = 2'b01;
            end
            DECODE:  alusrcb_s = 2'b11;
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            MEMRD:   iord_s = 1'b1;
            MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
            end
            RTYPEWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca_s  = 1'b1;
                aluop_s    = 2'b01;
                pcsrc_s    = 2'b01;
                branch_s   = (state_r == BEQEX);
                branchne_s = (state_r == BNEEX);
            end
            ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            ADDIWB:  regwrite_s = 1'b1;
            JEX: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: pcwrite_s = 1'b0;
        endcase
    end

    // ALU decoder; unknown funct codes fall back to add so the output is never X.
    always_comb begin
        alucontrol_s = 3'b010;
        case (aluop_s)
            2'b01:   alucontrol_s = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: alucontrol_s = 3'b010;
                    6'b100010: alucontrol_s = 3'b110;
                    6'b100100: alucontrol_s = 3'b000;
                    6'b100101: alucontrol_s = 3'b001;
                    6'b101010: alucontrol_s = 3'b111;
                    default:   alucontrol_s = 3'b010;
                endcase
            end
            default: alucontrol_s = 3'b010;
        endcase
    end

    // Output drive; write enables are gated by reset so an abort never writes.
    always_comb begin
        bus.pcen       = ~reset & (pcwrite_s | (branch_s & bus.zero) |
                                   (branchne_s & ~bus.zero));
        bus.irwrite    = ~reset & irwrite_s;
        bus.memwrite   = ~reset & memwrite_s;
        bus.regwrite   = ~reset & regwrite_s;
        bus.iord       = iord_s;
        bus.regdst     = regdst_s;
        bus.memtoreg   = memtoreg_s;
        bus.alusrca    = alusrca_s;
        bus.alusrcb    = alusrcb_s;
        bus.pcsrc      = pcsrc_s;
        bus.alucontrol = alucontrol_s;
        bus.state      = state_r;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level reference model (per-opcode state
// sequences and per-state control words) checked every cycle, plus literal checks.
module tb_mc_controller;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic [3:0] state;
    } ctl_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   seq[$];
    int   pos;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control word the spec table gives for state s.
    function automatic ctl_t expect_ctl(input int s, input logic z, input logic [5:0] f,
                                        input logic rst);
        ctl_t c;
        logic pw, br, bn;
        logic [1:0] aluop;
        c = '0; pw = 1'b0; br = 1'b0; bn = 1'b0; aluop = 2'b00;
        case (s)
            0:  begin c.irwrite = 1'b1; pw = 1'b1; c.alusrcb = 2'b01; end
            1:  c.alusrcb = 2'b11;
            2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            3:  c.iord = 1'b1;
            4:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            6:  begin c.alusrca = 1'b1; aluop = 2'b10; end
            7:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            8:  begin c.alusrca = 1'b1; aluop = 2'b01; c.pcsrc = 2'b01; br = 1'b1; end
            9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            10: c.regwrite = 1'b1;
            11: begin c.pcsrc = 2'b10; pw = 1'b1; end
            12: begin c.alusrca = 1'b1; aluop = 2'b01; c.pcsrc = 2'b01; bn = 1'b1; end
            default: c = '0;
        endcase
        if (aluop == 2'b01) c.alucontrol = 3'b110;
        else if (aluop == 2'b10) begin
            case (f)
                6'b100010: c.alucontrol = 3'b110;
                6'b100100: c.alucontrol = 3'b000;
                6'b100101: c.alucontrol = 3'b001;
                6'b101010: c.alucontrol = 3'b111;
                default:   c.alucontrol = 3'b010;
            endcase
        end else c.alucontrol = 3'b010;
        c.pcen = pw | (br & z) | (bn & ~z);
        if (rst) begin
            c.pcen = 1'b0; c.irwrite = 1'b0; c.memwrite = 1'b0; c.regwrite = 1'b0;
        end
        c.state = s[3:0];
        return c;
    endfunction

    function automatic int exp_lat(input logic [5:0] o);
        case (o)
            LW:                    return 5;
            SW, RT, ADDI:          return 4;
            BEQ, BNE, JMP:         return 3;
            default:               return 2;
        endcase
    endfunction

    // Reference model: per-instruction state sequence chosen from op at the decode edge.
    initial begin
        seq = '{0};
        pos = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                seq = '{0}; pos = 0;
            end else if (seq.size() == 1) begin
                case (bus.op)
                    LW:      seq = '{0, 1, 2, 3, 4};
                    SW:      seq = '{0, 1, 2, 5};
                    RT:      seq = '{0, 1, 6, 7};
                    BEQ:     seq = '{0, 1, 8};
                    BNE:     seq = '{0, 1, 12};
                    ADDI:    seq = '{0, 1, 9, 10};
                    JMP:     seq = '{0, 1, 11};
                    default: seq = '{0, 1};
                endcase
                pos = 1;
            end else if (pos + 1 < seq.size()) begin
                pos++;
            end else begin
                seq = '{0}; pos = 0;
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial begin
        ctl_t act, exp;
        forever begin
            @(negedge clk);
            exp = expect_ctl(seq[pos], bus.zero, bus.funct, reset);
            act = {bus.pcen, bus.iord, bus.irwrite, bus.memwrite, bus.regwrite, bus.regdst,
                   bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.state};
            chk("ctl_word", 32'(act), 32'(exp));
        end
    end

    // Runs one instruction starting just after an edge in FETCH; zmode 2 = random zero.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        int n;
        bus.op = o;
        bus.funct = f;
        bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        n = 1;
        forever begin
            @(posedge clk);
            #1;
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (bus.state == 4'd0) break;
            n++;
            if (n > 8) begin
                chk("fsm_timeout", 32'(n), 32'(exp_lat(o)));
                break;
            end
        end
        chk("latency", 32'(n), 32'(exp_lat(o)));
    endtask

    initial begin
        ctl_t m;
        logic [5:0] o, f;
        int n;
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;

        // Literal anchors for the model itself.
        m = expect_ctl(8, 1'b1, 6'b0, 1'b0);
        chk("model_beq_taken", {m.pcen, m.pcsrc, m.alucontrol}, {1'b1, 2'b01, 3'b110});
        m = expect_ctl(12, 1'b1, 6'b0, 1'b0);
        chk("model_bne_nottaken", 32'(m.pcen), 32'd0);
        m = expect_ctl(6, 1'b0, 6'b100010, 1'b0);
        chk("model_sub", {m.alucontrol, m.alusrca, m.alusrcb}, {3'b110, 1'b1, 2'b00});
        m = expect_ctl(0, 1'b0, 6'b0, 1'b1);
        chk("model_reset", {m.pcen, m.irwrite, m.alusrcb}, {1'b0, 1'b0, 2'b01});

        // Reset with clock running, then release mid-cycle.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.state, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite},
            {4'd0, 4'b0000});
        reset = 1'b0;
        #1;
        chk("release_fetch", {bus.state, bus.irwrite, bus.pcen, bus.alusrcb},
            {4'd0, 1'b1, 1'b1, 2'b01});

        // Directed instructions.
        run_instr(LW, 6'b0, 0);
        run_instr(SW, 6'b0, 0);
        run_instr(RT, 6'b100010, 0);
        run_instr(RT, 6'b101010, 1);
        run_instr(RT, 6'b100101, 0);
        run_instr(BEQ, 6'b0, 1);
        run_instr(BEQ, 6'b0, 0);
        run_instr(BNE, 6'b0, 0);
        run_instr(BNE, 6'b0, 1);
        run_instr(6'b111111, 6'b0, 0);
        run_instr(JMP, 6'b0, 0);
        run_instr(ADDI, 6'b0, 0);

        // Abort a store in MEMWR with an asynchronous reset.
        bus.op = SW; bus.funct = 6'b0; bus.zero = 1'b0;
        n = 0;
        while (bus.state != 4'd5 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_memwr", 32'(bus.state), 32'd5);
        reset = 1'b1;
        #1;
        chk("abort_memwr", {bus.state, bus.memwrite, bus.pcen, bus.regwrite},
            {4'd0, 3'b000});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("release2_fetch", {bus.irwrite, bus.pcen}, 2'b11);
        run_instr(SW, 6'b0, 0);
        run_instr(ADDI, 6'b0, 1);

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       o = LW;
                1:       o = SW;
                2:       o = RT;
                3:       o = BEQ;
                4:       o = BNE;
                5:       o = ADDI;
                6:       o = JMP;
                7:       o = RT;
                default: o = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 5))
                0:       f = 6'b100000;
                1:       f = 6'b100010;
                2:       f = 6'b100100;
                3:       f = 6'b100101;
                4:       f = 6'b101010;
                default: f = 6'($urandom_range(0, 63));
            endcase
            run_instr(o, f, 2);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle MIPS datapath built from the shared regfile, flopr/flopen, mux2/mux3/mux4, signext, sl2 and adder blocks.
- A Moore main FSM sequences fetch, decode, execute, memory and writeback, one state per clock.
- An ALU decoder turns aluop and funct into alucontrol.
- Combinational PC-enable logic resolves branches from the ALU zero flag.

Parameters:
None (state encoding is fixed at 4 bits).

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; forces FETCH
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag, same cycle as branch state
pcen  output  1  PC flopen enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
irwrite  output  1  instruction register enable
memwrite  output  1  data memory write enable
regwrite  output  1  register file we3
regdst  output  1  write address select: 0=rt, 1=rd
memtoreg  output  1  write data select: 0=ALUOut, 1=Data
alusrca  output  1  SrcA select: 0=PC, 1=A
alusrcb  output  2  SrcB select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  output  3  ALU function code
state  output  4  current state, for debug/verification

Behaviour:
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, bne 000101, addi 001000, j 000010. Any other opcode is illegal.
- State encodings and control words (any output not listed is 0):
  - FETCH 0: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE 1: alusrcb=11, aluop=00.
  - MEMADR 2: alusrca=1, alusrcb=10.
  - MEMRD 3: iord=1.
  - MEMWB 4: regwrite=1, memtoreg=1.
  - MEMWR 5: iord=1, memwrite=1.
  - RTYPEEX 6: alusrca=1, aluop=10.
  - RTYPEWB 7: regwrite=1, regdst=1.
  - BEQEX 8: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX 9: alusrca=1, alusrcb=10.
  - ADDIWB 10: regwrite=1.
  - JEX 11: pcsrc=10, pcwrite=1.
  - BNEEX 12: same as BEQEX but branchne=1 instead of branch.
  - Encodings 13-15 are unused.
- Transitions:
  - FETCH->DECODE.
  - DECODE->MEMADR (lw/sw), RTYPEEX, BEQEX, BNEEX, ADDIEX, JEX; illegal opcode ->FETCH.
  - MEMADR->MEMRD (lw) / MEMWR (sw).
  - MEMRD->MEMWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, ADDIWB, JEX ->FETCH.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
  - Unused encodings 13-15 ->FETCH on the next edge, with all enables 0 while in them.
- Instruction latencies, FETCH through last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero). This is combinational, evaluated in the same cycle as zero.
- ALU decoder (combinational):
  - aluop 00 ->010 (add); aluop 01 ->110 (sub); aluop 11 ->010.
  - aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct ->010.
  - The output is never X.
- Reset:
  - While reset is high, state=0 (FETCH).
  - pcen, irwrite, memwrite and regwrite are forced to 0, gated combinationally.
  - The select outputs show FETCH values: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010.
- Reset asserted mid-instruction aborts it immediately, with no further writes. After release, the first rising edge executes FETCH with enables active.
- op and funct are sampled only in DECODE/MEMADR and RTYPEEX respectively. The IR holds them stable, so no internal latching is required.
- The block holds no state other than the 4-bit state register.

Test Plan:
- Reset with clk running, then release: state=0, pcen=irwrite=regwrite=memwrite=0 during reset; the first edge after release gives irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011): state sequence 0,1,2,3,4,0; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1, regdst=0; exactly 5 cycles.
- R-type sub (op=0, funct=100010): RTYPEEX alucontrol=110, alusrca=1, alusrcb=00; RTYPEWB regwrite=1, regdst=1.
- beq with zero=1, then zero=0: in state 8, pcen=1 then pcen=0, pcsrc=01, alucontrol=110. Repeat for bne (state 12): pcen=0 then 1.
- Illegal op=111111: sequence 0,1,0; no regwrite/memwrite asserted. j (op=000010): state 11 with pcsrc=10, pcen=1.
- Assert reset during MEMWR (state 5): memwrite drops to 0 the same cycle and state=0 asynchronously; sw followed by addi runs normally after release (ADDIEX alusrcb=10; ADDIWB regwrite=1, regdst=0, memtoreg=0).
